// File: rtl/instr_fetch_unit.sv
// Sequential fetch stage: walks pc through instruction memory and issues one
// decoded instruction per ISSUE cycle to the opcode controller.
module instr_fetch_unit #(
  parameter int PC_W     = 6,
  parameter int END_ADDR = 63,
  parameter int FLD_W    = 7
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  output logic                   imem_rd,
  output logic [PC_W-1:0]        imem_addr,
  input  logic [2+3*FLD_W-1:0]   imem_data,
  input  logic                   imem_valid,
  input  logic                   stall,
  output logic                   instr_valid,
  output logic [1:0]             opcode,
  output logic [FLD_W-1:0]       src1,
  output logic [FLD_W-1:0]       src2,
  output logic [FLD_W-1:0]       dst,
  output logic [PC_W-1:0]        pc,
  output logic                   busy,
  output logic                   halted
);

  localparam int              IW      = 2 + 3*FLD_W;
  localparam logic [PC_W-1:0] END_PC  = PC_W'(END_ADDR);
  localparam logic [1:0]      OP_HALT = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_ISSUE = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  state_t            state_q, state_nxt;
  logic [PC_W-1:0]   pc_q, pc_nxt;
  logic [IW-1:0]     ir_q, ir_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_nxt;
      pc_q    <= pc_nxt;
      ir_q    <= ir_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    pc_nxt    = pc_q;
    ir_nxt    = ir_q;
    unique case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          pc_nxt    = '0;
          state_nxt = S_FETCH;
        end
      end
      S_FETCH: state_nxt = S_WAIT;
      S_WAIT: begin
        // A halt word is latched but never presented to the controller.
        if (imem_valid) begin
          ir_nxt    = imem_data;
          state_nxt = (imem_data[IW-1 -: 2] == OP_HALT) ? S_HALT : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!stall) begin
          if (pc_q == END_PC) begin
            state_nxt = S_HALT;
          end else begin
            pc_nxt    = pc_q + PC_W'(1);
            state_nxt = S_FETCH;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign imem_rd     = (state_q == S_FETCH);
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr_valid = (state_q == S_ISSUE);
  assign busy        = (state_q == S_FETCH) || (state_q == S_WAIT) || (state_q == S_ISSUE);
  assign halted      = (state_q == S_HALT);

  // Fields are gated so the controller sees zeros whenever nothing is issued.
  assign opcode = instr_valid ? ir_q[IW-1 -: 2]          : 2'b00;
  assign src1   = instr_valid ? ir_q[3*FLD_W-1 -: FLD_W] : '0;
  assign src2   = instr_valid ? ir_q[2*FLD_W-1 -: FLD_W] : '0;
  assign dst    = instr_valid ? ir_q[FLD_W-1:0]          : '0;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: a program-walk reference model fills
// expected fetch/issue queues; a negedge monitor pops and compares.
module tb_instr_fetch_unit;

  localparam int PC_W     = 6;
  localparam int END_ADDR = 15;
  localparam int FLD_W    = 7;
  localparam int IW       = 2 + 3*FLD_W;

  logic             clk = 1'b0;
  logic             reset, start, imem_rd, imem_valid, stall;
  logic             instr_valid, busy, halted;
  logic [PC_W-1:0]  imem_addr, pc;
  logic [IW-1:0]    imem_data;
  logic [1:0]       opcode;
  logic [FLD_W-1:0] src1, src2, dst;

  instr_fetch_unit #(.PC_W(PC_W), .END_ADDR(END_ADDR), .FLD_W(FLD_W)) dut (
    .clk(clk), .reset(reset), .start(start),
    .imem_rd(imem_rd), .imem_addr(imem_addr), .imem_data(imem_data),
    .imem_valid(imem_valid), .stall(stall),
    .instr_valid(instr_valid), .opcode(opcode), .src1(src1), .src2(src2), .dst(dst),
    .pc(pc), .busy(busy), .halted(halted)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [IW-1:0]        mem [64];
  int                   lat_tab [64];
  logic [PC_W-1:0]      fq [$];
  logic [PC_W+IW-1:0]   eq [$];

  bit            spur_en, stall_rand, ovr_en, ovr_valid;
  logic [IW-1:0] ovr_data;
  int            burst_target = 0;
  int            forced = 0;
  int            valid_cycles = 0;

  int              r_cnt = 0;
  bit              r_pend = 1'b0;
  logic [PC_W-1:0] r_addr = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory responder: returns mem[addr] lat_tab[addr] cycles after imem_rd.
  initial begin
    imem_valid = 1'b0;
    imem_data  = '0;
    forever begin
      @(posedge clk); #2;
      if (ovr_en) begin
        r_pend     = 1'b0;
        imem_valid = ovr_valid;
        imem_data  = ovr_data;
      end else if (r_pend) begin
        r_cnt--;
        if (r_cnt == 0) begin
          imem_valid = 1'b1;
          imem_data  = mem[r_addr];
          r_pend     = 1'b0;
        end else begin
          imem_valid = 1'b0;
          imem_data  = IW'($urandom);
        end
      end else if (imem_rd) begin
        r_pend     = 1'b1;
        r_addr     = imem_addr;
        r_cnt      = lat_tab[imem_addr];
        imem_valid = 1'b0;
      end else begin
        imem_valid = spur_en && ($urandom_range(0, 3) == 0);
        imem_data  = IW'($urandom);
      end
    end
  end

  // Stall driver: forced bursts while an instruction is presented, else random.
  initial begin
    stall = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (forced < burst_target && instr_valid) begin
        stall = 1'b1;
        forced++;
      end else begin
        stall = stall_rand && ($urandom_range(0, 2) == 0);
      end
    end
  end

  // Monitor
  initial begin
    forever begin
      @(negedge clk);
      if (imem_rd) begin
        if (fq.size() == 0) begin
          total++; bad++;
          $display("FAIL fetch_unexpected: imem_rd at addr %0d, no fetch expected", imem_addr);
        end else begin
          chk("fetch_addr", 64'(imem_addr), 64'(fq.pop_front()));
        end
      end
      if (instr_valid) begin
        valid_cycles++;
        if (eq.size() == 0) begin
          total++; bad++;
          $display("FAIL issue_unexpected: pc=%0d word=%0h, no issue expected", pc, {opcode, src1, src2, dst});
        end else begin
          chk("issue_pc_fields", 64'({pc, opcode, src1, src2, dst}), 64'(eq[0]));
          if (!stall) void'(eq.pop_front());
        end
      end else begin
        chk("fields_zero_when_invalid", 64'({opcode, src1, src2, dst}), 64'(0));
      end
    end
  end

  // Reference model: walk the program from address 0 until halt word or END_ADDR.
  task automatic plan(output int cyc, output int hpc);
    int a;
    a   = 0;
    cyc = 1;
    hpc = 0;
    while (1) begin
      fq.push_back(PC_W'(a));
      if (mem[a][IW-1 -: 2] == 2'b11) begin
        cyc += 1 + lat_tab[a];
        hpc  = a;
        break;
      end
      eq.push_back({PC_W'(a), mem[a]});
      cyc += lat_tab[a] + 2;
      if (a == END_ADDR) begin
        hpc = a;
        break;
      end
      a++;
    end
  endtask

  task automatic run_prog(input bit cyc_chk, input int extra, input bit rand_start);
    int exp_cyc, hpc, n;
    plan(exp_cyc, hpc);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 1;
    while (!halted && n < 3000) begin
      start = rand_start && busy && ($urandom_range(0, 7) == 0);
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    if (!halted) begin
      total++; bad++;
      $display("FAIL halt_timeout: no halt after %0d cycles, expected halt at pc %0d", n, hpc);
    end
    if (cyc_chk) chk("cycles_to_halt", 64'(n), 64'(exp_cyc + extra));
    chk("halt_pc", 64'(pc), 64'(hpc));
    chk("busy_at_halt", 64'(busy), 64'(0));
    chk("valid_at_halt", 64'(instr_valid), 64'(0));
    repeat (3) @(posedge clk);
    #1;
    chk("halt_pc_held", 64'(pc), 64'(hpc));
    chk("halted_held", 64'(halted), 64'(1));
    chk("issues_left", 64'(eq.size()), 64'(0));
    chk("fetches_left", 64'(fq.size()), 64'(0));
    eq.delete();
    fq.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int vc0;
    reset = 1'b1; start = 1'b0;
    spur_en = 1'b0; stall_rand = 1'b0;
    ovr_en = 1'b0; ovr_valid = 1'b0; ovr_data = '0;
    for (int i = 0; i < 64; i++) begin
      mem[i]     = '0;
      lat_tab[i] = 1;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", 64'({imem_rd, imem_addr, instr_valid, opcode, src1, src2, dst, pc, busy, halted}), 64'(0));
    reset = 1'b0;
    @(posedge clk); #1;
    chk("idle_outputs", 64'({imem_rd, imem_addr, instr_valid, opcode, src1, src2, dst, pc, busy, halted}), 64'(0));

    // Basic issue, minimum-latency timing
    mem[0] = {2'b00, 7'd1, 7'd2, 7'd3};
    mem[1] = {2'b01, 7'd4, 7'd5, 7'd6};
    mem[2] = {2'b11, 21'd0};
    run_prog(1'b1, 0, 1'b0);

    // Stall held for 4 cycles at address 0
    mem[0] = {2'b10, 7'd9, 7'd10, 7'd11};
    mem[1] = {2'b11, 21'h1FFFFF};
    vc0 = valid_cycles;
    burst_target = forced + 4;
    run_prog(1'b1, 4, 1'b0);
    chk("stall_valid_cycles", 64'(valid_cycles - vc0), 64'(5));

    // Slow memory at address 2, halt word at address 4
    for (int i = 0; i < 4; i++) mem[i] = {2'($urandom_range(0, 2)), 21'($urandom)};
    mem[4]     = {2'b11, 21'($urandom)};
    lat_tab[2] = 5;
    run_prog(1'b1, 0, 1'b0);
    lat_tab[2] = 1;

    // End of program at END_ADDR, no wrap and no fetch beyond it
    for (int i = 0; i <= END_ADDR + 1; i++) mem[i] = {2'b00, 21'($urandom)};
    run_prog(1'b1, 0, 1'b0);

    // Reset during WAIT, with memory answering in that cycle and the next
    fq.push_back('0);
    ovr_en = 1'b1;
    ovr_valid = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    ovr_valid = 1'b1;
    ovr_data  = {2'b00, 7'd7, 7'd7, 7'd7};
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("reset_in_wait_outputs", 64'({imem_rd, imem_addr, instr_valid, opcode, src1, src2, dst, pc, busy, halted}), 64'(0));
    @(posedge clk); #1;
    ovr_valid = 1'b0;
    chk("late_valid_ignored", 64'({imem_rd, imem_addr, instr_valid, opcode, src1, src2, dst, pc, busy, halted}), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    chk("idle_after_abort", 64'({busy, halted, instr_valid}), 64'(0));
    chk("abort_fetch_count", 64'(fq.size()), 64'(0));
    ovr_en = 1'b0;
    mem[0] = {2'b01, 7'd1, 7'd2, 7'd3};
    mem[1] = {2'b11, 21'd0};
    run_prog(1'b1, 0, 1'b0);

    // Randomized programs, latencies, stalls, spurious valids and ignored starts
    spur_en = 1'b1;
    stall_rand = 1'b1;
    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < 64; i++) begin
        mem[i]     = {(($urandom_range(0, 11) == 0) ? 2'b11 : 2'($urandom_range(0, 2))), 21'($urandom)};
        lat_tab[i] = $urandom_range(1, 4);
      end
      run_prog(1'b0, 0, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
